// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed hex display driver: scan states,
// digit count and the dwell counter sizing helper.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        OFF = 2'd0,
        ON  = 2'd1,
        GAP = 2'd2
    } scan_state_e;

    // Bits needed to hold max(a, b) - 1; never less than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Down-counter for the ON/GAP dwell: load the terminal value, done is high
// once the count has reached zero. Saturates at zero, never wraps.
module dwell_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/hex_scan_driver.sv
// Four-digit multiplexed hex display scanner with anti-ghosting gaps,
// double-buffered value loading at frame boundaries and leading-zero blanking.
module hex_scan_driver
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int GAP_CYC  = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    input  logic        blank_lz,
    output logic [3:0]  hex_out,
    output logic [3:0]  an_n,
    output logic        dp_n,
    output logic [1:0]  digit_idx
);

    localparam int CW = cnt_width(SCAN_DIV, GAP_CYC);
    localparam logic [CW-1:0] ON_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

    scan_state_e state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        cnt_load;
    logic [CW-1:0] cnt_value;
    logic        cnt_done;

    logic [15:0] active_q, active_d;
    logic [3:0]  active_dp_q, active_dp_d;
    logic [15:0] pend_q, pend_d;
    logic [3:0]  pend_dp_q, pend_dp_d;
    logic        pend_full_q, pend_full_d;

    logic [3:0]  an_n_q, an_n_d;
    logic        dp_n_q, dp_n_d;
    logic [3:0]  hex_q, hex_d;

    logic        accept;
    logic        frame_end;
    logic [NUM_DIGITS-1:0] lead_zero;

    dwell_counter #(
        .WIDTH (CW)
    ) u_dwell (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (cnt_load),
        .value_i (cnt_value),
        .done_o  (cnt_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_load  = 1'b0;
        cnt_value = '0;
        if (!enable) begin
            state_d  = OFF;
            idx_d    = '0;
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                OFF: begin
                    state_d   = ON;
                    idx_d     = '0;
                    cnt_load  = 1'b1;
                    cnt_value = ON_LAST;
                end
                ON: begin
                    if (cnt_done) begin
                        state_d   = GAP;
                        cnt_load  = 1'b1;
                        cnt_value = GAP_LAST;
                    end
                end
                GAP: begin
                    if (cnt_done) begin
                        state_d   = ON;
                        idx_d     = idx_q + 2'd1;
                        cnt_load  = 1'b1;
                        cnt_value = ON_LAST;
                    end
                end
                default: begin
                    state_d  = OFF;
                    idx_d    = '0;
                    cnt_load = 1'b1;
                end
            endcase
        end
    end

    // A load arriving exactly on a frame boundary bypasses pending entirely.
    assign load_ready = !pend_full_q;
    assign accept     = load_valid && !pend_full_q;
    assign frame_end  = (state_q == OFF) ||
                        ((state_q == GAP) && cnt_done && (idx_q == 2'd3));

    always_comb begin
        active_d    = active_q;
        active_dp_d = active_dp_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        if (frame_end) begin
            pend_full_d = 1'b0;
            if (accept) begin
                active_d    = load_data;
                active_dp_d = load_dp;
            end else if (pend_full_q) begin
                active_d    = pend_q;
                active_dp_d = pend_dp_q;
            end
        end else if (accept) begin
            pend_d      = load_data;
            pend_dp_d   = load_dp;
            pend_full_d = 1'b1;
        end
    end

    // Digit i is a leading zero when it and every higher nibble are zero.
    assign lead_zero[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
            assign lead_zero[gi] = (active_d[15:4*gi] == '0);
        end
    endgenerate

    always_comb begin
        an_n_d = 4'hF;
        dp_n_d = 1'b1;
        hex_d  = hex_q;
        if (state_d == ON) begin
            hex_d = active_d[{idx_d, 2'b00} +: 4];
            if (!(blank_lz && lead_zero[idx_d])) begin
                an_n_d[idx_d] = 1'b0;
                dp_n_d        = ~active_dp_d[idx_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= '0;
            active_dp_q <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
            an_n_q      <= 4'hF;
            dp_n_q      <= 1'b1;
            hex_q       <= '0;
        end else begin
            active_q    <= active_d;
            active_dp_q <= active_dp_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
            an_n_q      <= an_n_d;
            dp_n_q      <= dp_n_d;
            hex_q       <= hex_d;
        end
    end

    assign an_n      = an_n_q;
    assign dp_n      = dp_n_q;
    assign hex_out   = hex_q;
    assign digit_idx = idx_q;

endmodule
